// File: rtl/conv4_row_accum_if.sv
// conv4_row_accum_if : input beat and output beat handshake bundle for conv4_row_accum (rev 1.0)
`default_nettype none

interface conv4_row_accum_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 25
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*DATA_W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_data0;
  logic [ACC_W-1:0]      out_data1;
  logic                  out_lane1_vld;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_lane1_vld, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_lane1_vld, out_last
  );
endinterface

`default_nettype wire

// File: rtl/conv4_row_accum.sv
// conv4_row_accum : streaming 4x4 convolution of one output row, accumulated over channels (rev 1.0)
`default_nettype none

module conv4_row_accum #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 25,
  parameter int IMG_W  = 64,
  parameter int MAX_CH = 32,
  localparam int CH_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_start,
  input  logic [CH_W-1:0]  cfg_ci,
  input  logic             cfg_signed,
  conv4_row_accum_if.slave bus,
  output logic             busy,
  output logic             done
);
  localparam int OUT_W  = IMG_W - 3;
  localparam int N_BEAT = IMG_W / 2;
  localparam int N_DR   = (OUT_W + 1) / 2;
  localparam int CW     = $clog2(N_BEAT);
  localparam int DW     = $clog2(N_DR + 1);
  localparam int IDX_W  = $clog2(OUT_W);
  localparam int PW     = 2 * DATA_W + 6;
  localparam int SW     = (ACC_W > PW) ? ACC_W : PW;

  typedef enum logic [2:0] {S_IDLE, S_K0, S_K1, S_DATA, S_DRAIN} state_t;

  typedef logic [3:0][3:0][DATA_W-1:0] win_t;

  state_t                     state;
  logic [CH_W-1:0]            ci;
  logic                       sgn;
  logic [CH_W-1:0]            ch;
  logic [CW-1:0]              col;
  logic [DW-1:0]              dcnt;
  win_t                       kern;
  logic [2:0][3:0][DATA_W-1:0] hist;
  logic [ACC_W-1:0]           acc [OUT_W];

  logic [4:0][3:0][DATA_W-1:0] cols;
  logic [ACC_W-1:0]           res_a, res_b;
  logic [IDX_W-1:0]           idx_a, idx_b, lo_idx, hi_idx;
  logic                       hi_ok;
  logic                       take;

  // Full-precision products summed modulo 2^SW; SW covers both the exact sum and ACC_W.
  function automatic logic [ACC_W-1:0] mac(input win_t k, input win_t w, input logic s);
    logic [SW-1:0] sum, a, b;
    sum = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a   = {{(SW-DATA_W){s & k[r][c][DATA_W-1]}}, k[r][c]};
        b   = {{(SW-DATA_W){s & w[c][r][DATA_W-1]}}, w[c][r]};
        sum = sum + a * b;
      end
    end
    return ACC_W'(sum);
  endfunction

  assign take         = bus.in_valid & bus.in_ready;
  assign bus.in_ready = (state == S_K0) | (state == S_K1) | (state == S_DATA);
  assign busy         = (state != S_IDLE);

  // cols[0..2] are columns 2j-3..2j-1 kept from earlier beats, cols[3..4] arrive now.
  always_comb begin
    cols   = {bus.in_data, hist};
    res_a  = mac(kern, cols[3:0], sgn);
    res_b  = mac(kern, cols[4:1], sgn);
    idx_a  = IDX_W'(2 * 32'(col) - 3);
    idx_b  = IDX_W'(2 * 32'(col) - 2);
    lo_idx = IDX_W'(2 * 32'(dcnt));
    hi_ok  = (2 * 32'(dcnt) + 1) < 32'(OUT_W);
    hi_idx = hi_ok ? IDX_W'(2 * 32'(dcnt) + 1) : lo_idx;
  end

  always_ff @(posedge clk) begin
    if (state == S_K0 && take) kern[1:0] <= bus.in_data;
    if (state == S_K1 && take) kern[3:2] <= bus.in_data;
    if (state == S_DATA && take) begin
      hist <= cols[4:2];
      if (col > CW'(1))
        acc[idx_a] <= (ch == '0) ? res_a : acc[idx_a] + res_a;
      if (col != '0)
        acc[idx_b] <= (ch == '0) ? res_b : acc[idx_b] + res_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      ci                <= '0;
      sgn               <= 1'b0;
      ch                <= '0;
      col               <= '0;
      dcnt              <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_data0     <= '0;
      bus.out_data1     <= '0;
      bus.out_lane1_vld <= 1'b0;
      bus.out_last      <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_start) begin
            ci    <= cfg_ci;
            sgn   <= cfg_signed;
            ch    <= '0;
            col   <= '0;
            state <= S_K0;
          end
        end
        S_K0: if (take) state <= S_K1;
        S_K1: if (take) state <= S_DATA;
        S_DATA: begin
          if (take) begin
            if (col == CW'(N_BEAT - 1)) begin
              col <= '0;
              if (ch == ci) begin
                dcnt  <= '0;
                state <= S_DRAIN;
              end else begin
                ch    <= ch + 1'b1;
                state <= S_K0;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.out_valid && bus.out_ready && bus.out_last) begin
            bus.out_valid     <= 1'b0;
            bus.out_data0     <= '0;
            bus.out_data1     <= '0;
            bus.out_lane1_vld <= 1'b0;
            bus.out_last      <= 1'b0;
            done              <= 1'b1;
            state             <= S_IDLE;
          end else if (!bus.out_valid || bus.out_ready) begin
            // First load waits one cycle so the final data beat's writes have landed.
            bus.out_valid     <= 1'b1;
            bus.out_data0     <= acc[lo_idx];
            bus.out_data1     <= hi_ok ? acc[hi_idx] : '0;
            bus.out_lane1_vld <= hi_ok;
            bus.out_last      <= (dcnt == DW'(N_DR - 1));
            dcnt              <= dcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_conv4_row_accum.sv
// tb_conv4_row_accum : scoreboard bench, two instances (ACC_W 25 and 16) driven in lockstep
`default_nettype none

module tb_conv4_row_accum;
  localparam int IMG  = 8;
  localparam int OUTW = IMG - 3;
  localparam int NDR  = (OUTW + 1) / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [4:0]  cfg_ci = '0;
  logic        cfg_signed = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        busy_a, done_a, busy_b, done_b;

  conv4_row_accum_if #(.DATA_W(8), .ACC_W(25)) ifa ();
  conv4_row_accum_if #(.DATA_W(8), .ACC_W(16)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  conv4_row_accum #(.DATA_W(8), .ACC_W(25), .IMG_W(IMG), .MAX_CH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .cfg_ci(cfg_ci),
    .cfg_signed(cfg_signed), .bus(ifa), .busy(busy_a), .done(done_a)
  );

  conv4_row_accum #(.DATA_W(8), .ACC_W(16), .IMG_W(IMG), .MAX_CH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .cfg_ci(cfg_ci),
    .cfg_signed(cfg_signed), .bus(ifb), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] d0;
    logic [24:0] d1;
    logic        l1;
    logic        last;
  } beat_t;

  beat_t       q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          ready_miss = 0;
  int          in_pct = 0;
  int          out_pct = 0;
  logic [7:0]  K [3][4][4];
  logic [7:0]  D [3][4][IMG];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic longint lv(input logic [7:0] x, input bit s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  // Reference model straight from the convolution definition.
  task automatic push_expect(input int nch, input bit sgn);
    longint s [OUTW];
    beat_t  bt;
    for (int p = 0; p < OUTW; p++) begin
      s[p] = 0;
      for (int c = 0; c < nch; c++)
        for (int r = 0; r < 4; r++)
          for (int k = 0; k < 4; k++)
            s[p] += lv(K[c][r][k], sgn) * lv(D[c][r][p+k], sgn);
      s[p] = s[p] & ((longint'(1) << 25) - 1);
    end
    for (int b = 0; b < NDR; b++) begin
      bt.d0   = 25'(s[2*b]);
      bt.l1   = (2*b + 1 < OUTW);
      bt.d1   = bt.l1 ? 25'(s[2*b+1]) : 25'(0);
      bt.last = (b == NDR - 1);
      q.push_back(bt);
    end
  endtask

  logic        hold = 1'b0;
  logic [24:0] h0 = '0, h1 = '0;

  always @(negedge clk) begin
    if (done_a) done_cnt <= done_cnt + 1;
    if (hold) begin
      chk("stall_hold_d0", ifa.out_data0, h0);
      chk("stall_hold_d1", ifa.out_data1, h1);
    end
    if (ifa.out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        chk("out_data0", ifa.out_data0, q[0].d0);
        chk("out_data1", ifa.out_data1, q[0].d1);
        chk("out_lane1_vld", ifa.out_lane1_vld, q[0].l1);
        chk("out_last", ifa.out_last, q[0].last);
        chk("acc16_data0", ifb.out_data0, q[0].d0[15:0]);
        chk("acc16_data1", ifb.out_data1, q[0].d1[15:0]);
        q.delete(0);
      end
    end
    hold <= ifa.out_valid && !out_ready;
    h0   <= ifa.out_data0;
    h1   <= ifa.out_data1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (out_pct == 0) ? 1'b1 : ($urandom_range(99) >= out_pct);
    end
  end

  task automatic send(input logic [63:0] d);
    bit ok;
    int t;
    while (in_pct != 0 && $urandom_range(99) < in_pct) begin
      in_valid = 1'b0;
      in_data  = 64'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = ifa.in_ready;
      if (!ok) ready_miss++;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 100);
    if (!ok) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_channel(input int c, input int nbeats);
    logic [63:0] w;
    for (int l = 0; l < 4; l++) begin
      w[8*l +: 8]     = K[c][0][l];
      w[8*(l+4) +: 8] = K[c][1][l];
    end
    send(w);
    for (int l = 0; l < 4; l++) begin
      w[8*l +: 8]     = K[c][2][l];
      w[8*(l+4) +: 8] = K[c][3][l];
    end
    send(w);
    for (int j = 0; j < nbeats; j++) begin
      for (int r = 0; r < 4; r++) begin
        w[8*r +: 8]     = D[c][r][2*j];
        w[8*(r+4) +: 8] = D[c][r][2*j+1];
      end
      send(w);
    end
  endtask

  task automatic fill(input logic [7:0] kv, input logic [7:0] dv);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) K[c][r][k] = kv;
        for (int x = 0; x < IMG; x++) D[c][r][x] = dv;
      end
  endtask

  // in_start is held high with scrambled cfg while busy; the engine must ignore both.
  task automatic run(input int nch, input bit sgn, input string tag);
    int d0, m0, t;
    d0 = done_cnt;
    m0 = ready_miss;
    push_expect(nch, sgn);
    in_start   = 1'b1;
    cfg_ci     = 5'(nch - 1);
    cfg_signed = sgn;
    @(posedge clk);
    #1;
    cfg_ci     = 5'($urandom);
    cfg_signed = ~sgn;
    for (int c = 0; c < nch; c++) send_channel(c, IMG / 2);
    in_start = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_beats_left"}, q.size(), 0);
    chk({tag, "_busy_end"}, busy_a, 0);
    if (in_pct == 0) chk({tag, "_in_ready_gaps"}, ready_miss - m0, 0);
    q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_in_ready"}, ifa.in_ready, 0);
    chk({tag, "_out_valid"}, ifa.out_valid, 0);
    chk({tag, "_out_last"}, ifa.out_last, 0);
    chk({tag, "_lane1_vld"}, ifa.out_lane1_vld, 0);
    chk({tag, "_data0"}, ifa.out_data0, 0);
    chk({tag, "_data1"}, ifa.out_data1, 0);
    chk({tag, "_done"}, done_a, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    fill(8'd1, 8'd1);
    run(1, 1'b0, "basic");
    run(3, 1'b0, "accum3");

    fill(8'hFF, 8'h02);
    run(1, 1'b1, "signed");
    run(1, 1'b0, "unsigned");

    fill(8'hFF, 8'hFF);
    run(2, 1'b0, "wrap");

    fill(8'd0, 8'd0);
    K[0][0][0] = 8'd1;
    for (int r = 0; r < 4; r++)
      for (int x = 0; x < IMG; x++) D[0][r][x] = 8'(x);
    run(1, 1'b0, "position");

    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) K[c][r][k] = 8'($urandom);
        for (int x = 0; x < IMG; x++) D[c][r][x] = 8'($urandom);
      end
    in_pct  = 30;
    out_pct = 40;
    run(3, 1'b1, "stall_signed");
    run(2, 1'b0, "stall_unsigned");
    in_pct  = 0;
    out_pct = 0;

    // Abort mid-DATA, then a fresh run must be unaffected by the partial sums.
    fill(8'd3, 8'd5);
    in_start   = 1'b1;
    cfg_ci     = 5'd0;
    cfg_signed = 1'b0;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    send_channel(0, 2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("midrun_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill(8'd1, 8'd1);
    run(1, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/conv4_row_accum.md
Name: conv4_row_accum

Overview:
- Parametrised successor to the fixed 61x61 CONV top: a streaming 4x4 convolution engine that computes one output row and accumulates it across a configurable number of input channels.
- Each channel is fed through a valid/ready port: a 2-beat kernel load, then the image row-slab in 2-column beats, at 8 values per beat.
- After the last channel, the engine drains the accumulated row two results per beat through a valid/ready output port. A row-sequencer upstream calls it once per output row.

Parameters:
- DATA_W, 8, width of each input lane (kernel and data).
- ACC_W, 25, width of the accumulator and output results. Results wrap modulo 2^ACC_W.
- IMG_W, 64, input slab width in columns. Must be even and >= 6. OUT_W = IMG_W-3.
- MAX_CH, 32, maximum channel count. CH_W = clog2(MAX_CH).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_start  in  1  start pulse. cfg_* are latched on it; it is ignored unless IDLE.
- cfg_ci  in  CH_W  channels minus 1 (0 means 1 channel)
- cfg_signed  in  1  1 = two's-complement lanes, 0 = unsigned
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts the beat
- in_data  in  8*DATA_W  lanes 0..7, lane0 in the LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the output beat
- out_data0  out  ACC_W  result at column 2n
- out_data1  out  ACC_W  result at column 2n+1
- out_lane1_vld  out  1  out_data1 is meaningful
- out_last  out  1  final beat of the row
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last output beat handshakes

Behaviour:
- Reset: all state is cleared. State=IDLE; in_ready, out_valid, out_last, out_lane1_vld, busy and done are 0; out_data0/1 are 0; channel and column counters are 0.
- Handshake rule: a beat transfers only when valid&ready are both high on a rising edge. A source holds its payload until the transfer.
- States:
  - IDLE -> K0 on in_start.
  - K0: accepts kernel rows 0-1. Lanes 0-3 are k[0][0..3], lanes 4-7 are k[1][0..3]. -> K1 on transfer.
  - K1: accepts kernel rows 2-3 in the same layout. -> DATA on transfer.
  - DATA: each beat carries two columns. Lanes 0-3 are rows 0-3 of column 2j; lanes 4-7 are rows 0-3 of column 2j+1. IMG_W/2 beats per channel.
    - After the last beat: if more channels remain, channel++ and -> K0. Otherwise -> DRAIN.
  - DRAIN: emits ceil(OUT_W/2) beats. -> IDLE when the last beat transfers; done pulses on the next cycle.
- in_ready: 1 in K0, K1 and DATA; 0 in IDLE and DRAIN.
- Window: a 4x4 window register shifts left by two columns on each accepted data beat.
  - Beat j=1 produces result 0.
  - Each beat j>=2 produces results 2j-3 and 2j-2.
  - Beat j=0 produces nothing. Total per channel is OUT_W.
- MAC: result = sum of the 16 products k*d. Operands are sign- or zero-extended per the latched cfg_signed. Full-precision products, then the sum is truncated to ACC_W.
- Accumulation: the accumulator buffer is OUT_W x ACC_W.
  - Channel 0 overwrites its entries. No clear cycle is needed.
  - Channels 1..ci add into existing entries modulo 2^ACC_W.
  - Update is registered on the accepting edge, so there is no backpressure from the MAC path.
- Output: out_data0/1 are registered and stable while out_valid&!out_ready.
  - When OUT_W is odd, the final beat has out_lane1_vld=0 and out_data1=0.
  - out_last=1 only on the final beat. out_lane1_vld=1 on all other beats.
- Stalls: in_valid low in K0/K1/DATA holds all state. out_ready low in DRAIN holds the beat. Stalls have no cycle limit.
- in_start while busy is ignored, and cfg changes while busy have no effect.
- Reset mid-operation: rst_n=0 on any edge returns to the reset state and discards partial sums. The next run must begin with in_start.
- Throughput: 2 kernel beats plus IMG_W/2 data beats per channel, and ceil(OUT_W/2) drain beats, all at one beat per cycle when unstalled.

Test Plan:
- Basic unsigned (IMG_W=8, C=1): kernel all 1, data all 1 -> 3 output beats of (16,16),(16,16),(16,x). The last beat has lane1_vld=0, out_last=1, and done pulses once.
- Channel accumulate (IMG_W=8, cfg_ci=2): same stimulus for 3 channels -> all five results 48. in_ready stays high through each K0/K1 re-load.
- Signed mode (cfg_signed=1): kernel 0xFF, data 0x02 -> every result -32, i.e. 2^25-32. The same stimulus with cfg_signed=0 -> 8160.
- Wrap (ACC_W=16, cfg_ci=1, unsigned): kernel and data 0xFF -> every result 2080800 mod 65536 = 49184.
- Position check (IMG_W=8): kernel has 1 only at k[0][0]; data value = column index -> results 0,1,2,3,4 in order.
- Backpressure/reset: random in_valid and out_ready gaps -> results identical to the unstalled run and out_data stable while stalled. rst_n=0 mid-DATA -> IDLE and all outputs 0; a fresh run is then correct.
